alu_issue_stage: RTL and testbench
==================================

# alu_issue_stage

Issue stage directly upstream of the RV32I ALU. Accepts one decoded instruction per cycle from decode and selects the two ALU operands. Forms the 4-bit ALU opcode and masks shift amounts to 5 bits. Holds the results in a 2-entry skid buffer with valid/ready handshakes on both sides, so the ALU sees registered operands and decode backpressure is fully decoupled.

## Interface
Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- DEPTH, 2, skid buffer entries; fixed at 2.

Ports:
- clk_in  input  1  clock; all state updates on rising edge.
- rst_in  input  1  reset, asynchronous, active-high.
- flush_in  input  1  synchronous flush; empties the buffer.
- valid_in  input  1  decode presents an instruction.
- ready_out  output  1  stage can accept; equals (count < 2), independent of ready_in.
- opcode_in  input  7  instruction opcode field.
- funct3_in  input  3  funct3 field.
- funct7_5_in  input  1  instruction bit 30.
- rd_in  input  5  destination register, passed through.
- rs1_data_in, rs2_data_in  input  32  register file read data.
- imm_in  input  32  sign-extended immediate from decode.
- pc_in  input  32  instruction address.
- valid_out  output  1  head entry valid.
- ready_in  input  1  ALU side consumes the head entry.
- op_1_out, op_2_out  output  32  ALU operands.
- alu_opcode_out  output  4  ALU operation code.
- rd_out  output  5  destination register of the head entry.
- illegal_out  output  1  head entry carries an unsupported opcode.

## Operation
Decode is combinational on the inputs and is captured on push. A push occurs when valid_in & ready_out. A pop occurs when valid_out & ready_in.

Decode rules:
- OP (0110011):
  - op1 = rs1, op2 = rs2.
  - For funct3 001/101, op2 = {27'b0, rs2[4:0]}.
  - alu_opcode = {b3, funct3}, where b3 = funct7_5 if funct3 ∈ {000, 101}, else 0.
- OP_IMM (0010011):
  - op1 = rs1, op2 = imm.
  - For funct3 001/101, op2 = {27'b0, imm[4:0]}.
  - b3 = funct7_5 only when funct3 = 101; otherwise b3 = 0, so ADDI never becomes SUB.
- LUI (0110111): op1 = 0, op2 = imm, alu_opcode = 0000.
- AUIPC (0010111): op1 = pc, op2 = imm, alu_opcode = 0000.
- LOAD (0000011) / STORE (0100011): op1 = rs1, op2 = imm, alu_opcode = 0000.
- JAL (1101111) / JALR (1100111): op1 = pc, op2 = 32'd4, alu_opcode = 0000 (link value).
- Any other opcode: op1 = op2 = 0, alu_opcode = 0000, illegal = 1. The entry is still buffered and delivered in order.

Buffer:
- FIFO order, count in 0..2. Outputs always reflect the head entry.
- Push only: count+1. Pop only: count−1. Push and pop together: count unchanged, and the new entry enters behind the head.
- Push and pop together at count = 0 cannot occur, because valid_out = 0.
- At count = 2, ready_out = 0, so no push is possible.
- flush_in has priority over push and pop: count → 0 next cycle, and any push in that cycle is dropped.

## Timing
- Reset values: count = 0, valid_out = 0, and op_1_out, op_2_out, alu_opcode_out, rd_out, illegal_out all 0. ready_out = 1 immediately once reset is asserted.
- Reset mid-operation discards all entries asynchronously. No output glitches to a valid state during reset.
- Latency: an instruction pushed in cycle N is on the outputs with valid_out = 1 in cycle N+1.
- Throughput: 1 instruction per cycle while ready_in = 1.
- Head outputs stay stable while valid_out & !ready_in.
- ready_in low for 2 or more cycles with continuous valid_in: count reaches 2 and ready_out drops one cycle after the second push.
- After flush: valid_out = 0 and ready_out = 1 in the next cycle.

## Structure
- Shared package rv32i_pkg holds:
  - the 7-bit opcode constants listed above;
  - the ALU opcode constants (ADD 0000, SUB 1000, SLT 0010, SLTU 0011, AND 0111, OR 0110, XOR 0100, SLL 0001, SRL 0101, SRA 1101);
  - the buffer entry struct {op1, op2, alu_opcode, rd, illegal}.
- One sub-module, alu_op_decode, contains the purely combinational operand and opcode selection. The top level contains the 2-entry buffer, the count and the handshakes.

## Test plan
- Reset mid-stream with count = 2 → next cycle count = 0, valid_out = 0, ready_out = 1, and all data outputs 0.
- OP SUB: rs1 = 10, rs2 = 3, funct3 = 000, f7_5 = 1 → next cycle alu_opcode = 1000, op1 = 10, op2 = 3. OP_IMM ADDI with imm = −1 and bit 30 = 1 → alu_opcode = 0000.
- SRAI: imm = 0x0000_0405 → op2 = 5, alu_opcode = 1101. SLL with rs2 = 0xFFFF_FFE3 → op2 = 3, alu_opcode = 0001.
- Backpressure: hold ready_in = 0 and push 3 back-to-back instructions → ready_out = 0 after the 2nd push, the 3rd is held by decode. Release ready_in → all 3 delivered in order, one per cycle.
- JAL with pc = 0x100 → op1 = 0x100, op2 = 4. Opcode 1110011 → illegal_out = 1, operands 0.
- Flush with count = 2 and valid_in = 1 in the same cycle → next cycle count = 0, the pushed instruction is dropped, valid_out = 0.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared RV32I constants and the issue-stage buffer entry layout.
package rv32i_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_AND  = 4'b0111;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SRA  = 4'b1101;

  typedef struct packed {
    logic [31:0] op1;
    logic [31:0] op2;
    logic [3:0]  alu_opcode;
    logic [4:0]  rd;
    logic        illegal;
  } issue_entry_t;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational operand and ALU opcode selection for one decoded instruction.
module alu_op_decode
  import rv32i_pkg::*;
(
  input  logic [6:0]   opcode_in,
  input  logic [2:0]   funct3_in,
  input  logic         funct7_5_in,
  input  logic [4:0]   rd_in,
  input  logic [31:0]  rs1_data_in,
  input  logic [31:0]  rs2_data_in,
  input  logic [31:0]  imm_in,
  input  logic [31:0]  pc_in,
  output issue_entry_t entry_out
);

  logic is_shift_s;
  assign is_shift_s = (funct3_in == 3'b001) || (funct3_in == 3'b101);

  // Operand muxing and opcode formation per instruction class
  always_comb begin
    entry_out            = '0;
    entry_out.rd         = rd_in;
    entry_out.alu_opcode = ALU_ADD;
    case (opcode_in)
      OPC_OP: begin
        entry_out.op1 = rs1_data_in;
        if (is_shift_s) entry_out.op2 = {27'd0, rs2_data_in[4:0]};
        else            entry_out.op2 = rs2_data_in;
        if ((funct3_in == 3'b000) || (funct3_in == 3'b101))
          entry_out.alu_opcode = {funct7_5_in, funct3_in};
        else
          entry_out.alu_opcode = {1'b0, funct3_in};
      end
      OPC_OP_IMM: begin
        entry_out.op1 = rs1_data_in;
        if (is_shift_s) entry_out.op2 = {27'd0, imm_in[4:0]};
        else            entry_out.op2 = imm_in;
        // Bit 30 is part of the immediate for ADDI, so only SRAI honours it
        if (funct3_in == 3'b101) entry_out.alu_opcode = {funct7_5_in, funct3_in};
        else                     entry_out.alu_opcode = {1'b0, funct3_in};
      end
      OPC_LUI: begin
        entry_out.op1 = 32'd0;
        entry_out.op2 = imm_in;
      end
      OPC_AUIPC: begin
        entry_out.op1 = pc_in;
        entry_out.op2 = imm_in;
      end
      OPC_LOAD, OPC_STORE: begin
        entry_out.op1 = rs1_data_in;
        entry_out.op2 = imm_in;
      end
      OPC_JAL, OPC_JALR: begin
        entry_out.op1 = pc_in;
        entry_out.op2 = 32'd4;
      end
      default: begin
        entry_out.op1     = 32'd0;
        entry_out.op2     = 32'd0;
        entry_out.illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/alu_issue_stage.sv
// RV32I ALU issue stage: operand decode feeding a 2-entry skid buffer.
module alu_issue_stage
  import rv32i_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic            clk_in,
  input  logic            rst_in,
  input  logic            flush_in,
  input  logic            valid_in,
  output logic            ready_out,
  input  logic [6:0]      opcode_in,
  input  logic [2:0]      funct3_in,
  input  logic            funct7_5_in,
  input  logic [4:0]      rd_in,
  input  logic [XLEN-1:0] rs1_data_in,
  input  logic [XLEN-1:0] rs2_data_in,
  input  logic [XLEN-1:0] imm_in,
  input  logic [XLEN-1:0] pc_in,
  output logic            valid_out,
  input  logic            ready_in,
  output logic [XLEN-1:0] op_1_out,
  output logic [XLEN-1:0] op_2_out,
  output logic [3:0]      alu_opcode_out,
  output logic [4:0]      rd_out,
  output logic            illegal_out
);

  issue_entry_t dec_s;
  issue_entry_t head_r;
  issue_entry_t tail_r;
  logic         head_vld_r;
  logic         tail_vld_r;
  logic [1:0]   count_s;
  logic         push_s;
  logic         pop_s;

  alu_op_decode u_dec (
    .opcode_in   (opcode_in),
    .funct3_in   (funct3_in),
    .funct7_5_in (funct7_5_in),
    .rd_in       (rd_in),
    .rs1_data_in (rs1_data_in),
    .rs2_data_in (rs2_data_in),
    .imm_in      (imm_in),
    .pc_in       (pc_in),
    .entry_out   (dec_s)
  );

  assign count_s   = {1'b0, head_vld_r} + {1'b0, tail_vld_r};
  assign ready_out = ({30'd0, count_s} < DEPTH[31:0]);
  assign valid_out = head_vld_r;
  assign push_s    = valid_in & ready_out;
  assign pop_s     = valid_out & ready_in;

  // Head slot drives the outputs directly so the ALU sees registered values
  assign op_1_out       = head_r.op1;
  assign op_2_out       = head_r.op2;
  assign alu_opcode_out = head_r.alu_opcode;
  assign rd_out         = head_r.rd;
  assign illegal_out    = head_r.illegal;

  // Shift-style FIFO: slot 0 is always the head, slot 1 the entry behind it
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      head_r     <= '0;
      tail_r     <= '0;
      head_vld_r <= 1'b0;
      tail_vld_r <= 1'b0;
    end else if (flush_in) begin
      head_vld_r <= 1'b0;
      tail_vld_r <= 1'b0;
    end else begin
      case ({push_s, pop_s})
        2'b10: begin
          if (!head_vld_r) begin
            head_r     <= dec_s;
            head_vld_r <= 1'b1;
          end else begin
            tail_r     <= dec_s;
            tail_vld_r <= 1'b1;
          end
        end
        2'b01: begin
          head_r     <= tail_r;
          head_vld_r <= tail_vld_r;
          tail_vld_r <= 1'b0;
        end
        2'b11: begin
          if (tail_vld_r) begin
            head_r <= tail_r;
            tail_r <= dec_s;
          end else begin
            head_r <= dec_s;
          end
        end
        default: begin
          head_vld_r <= head_vld_r;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed self-checking bench for alu_issue_stage.
module tb_alu_issue_stage;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        flush_in;
  logic        valid_in;
  logic        ready_out;
  logic [6:0]  opcode_in;
  logic [2:0]  funct3_in;
  logic        funct7_5_in;
  logic [4:0]  rd_in;
  logic [31:0] rs1_data_in;
  logic [31:0] rs2_data_in;
  logic [31:0] imm_in;
  logic [31:0] pc_in;
  logic        valid_out;
  logic        ready_in;
  logic [31:0] op_1_out;
  logic [31:0] op_2_out;
  logic [3:0]  alu_opcode_out;
  logic [4:0]  rd_out;
  logic        illegal_out;

  int n_checks = 0;
  int n_fails  = 0;

  alu_issue_stage dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .flush_in       (flush_in),
    .valid_in       (valid_in),
    .ready_out      (ready_out),
    .opcode_in      (opcode_in),
    .funct3_in      (funct3_in),
    .funct7_5_in    (funct7_5_in),
    .rd_in          (rd_in),
    .rs1_data_in    (rs1_data_in),
    .rs2_data_in    (rs2_data_in),
    .imm_in         (imm_in),
    .pc_in          (pc_in),
    .valid_out      (valid_out),
    .ready_in       (ready_in),
    .op_1_out       (op_1_out),
    .op_2_out       (op_2_out),
    .alu_opcode_out (alu_opcode_out),
    .rd_out         (rd_out),
    .illegal_out    (illegal_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic drive(input logic [6:0] opc, input logic [2:0] f3, input logic f75,
                       input logic [4:0] rd, input logic [31:0] rs1, input logic [31:0] rs2,
                       input logic [31:0] imm, input logic [31:0] pc);
    valid_in    = 1'b1;
    opcode_in   = opc;
    funct3_in   = f3;
    funct7_5_in = f75;
    rd_in       = rd;
    rs1_data_in = rs1;
    rs2_data_in = rs2;
    imm_in      = imm;
    pc_in       = pc;
  endtask

  task automatic check_empty_zero(input string tag);
    check({tag, "_valid"}, {31'd0, valid_out}, 32'd0);
    check({tag, "_ready"}, {31'd0, ready_out}, 32'd1);
    check({tag, "_op1"}, op_1_out, 32'd0);
    check({tag, "_op2"}, op_2_out, 32'd0);
    check({tag, "_aluop"}, {28'd0, alu_opcode_out}, 32'd0);
    check({tag, "_rd"}, {27'd0, rd_out}, 32'd0);
    check({tag, "_illegal"}, {31'd0, illegal_out}, 32'd0);
  endtask

  task automatic check_head(input string tag, input logic [31:0] op1, input logic [31:0] op2,
                            input logic [3:0] aop, input logic [4:0] rd, input logic ill);
    check({tag, "_valid"}, {31'd0, valid_out}, 32'd1);
    check({tag, "_op1"}, op_1_out, op1);
    check({tag, "_op2"}, op_2_out, op2);
    check({tag, "_aluop"}, {28'd0, alu_opcode_out}, {28'd0, aop});
    check({tag, "_rd"}, {27'd0, rd_out}, {27'd0, rd});
    check({tag, "_illegal"}, {31'd0, illegal_out}, {31'd0, ill});
  endtask

  initial begin
    rst_in   = 1'b1;
    flush_in = 1'b0;
    ready_in = 1'b1;
    drive(7'b0110011, 3'b000, 1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    valid_in = 1'b0;
    #2;
    check_empty_zero("reset");
    @(posedge clk_in);
    #1;
    rst_in = 1'b0;

    // Single-cycle pipeline of decode cases, ready_in held high
    drive(7'b0110011, 3'b000, 1'b1, 5'd7, 32'd10, 32'd3, 32'd0, 32'd0);
    tick();
    check_head("sub", 32'd10, 32'd3, 4'b1000, 5'd7, 1'b0);
    drive(7'b0010011, 3'b000, 1'b1, 5'd8, 32'd20, 32'd0, 32'hFFFF_FFFF, 32'd0);
    tick();
    check_head("addi", 32'd20, 32'hFFFF_FFFF, 4'b0000, 5'd8, 1'b0);
    drive(7'b0010011, 3'b101, 1'b1, 5'd9, 32'h8000_0000, 32'd0, 32'h0000_0405, 32'd0);
    tick();
    check_head("srai", 32'h8000_0000, 32'd5, 4'b1101, 5'd9, 1'b0);
    drive(7'b0110011, 3'b001, 1'b0, 5'd10, 32'd1, 32'hFFFF_FFE3, 32'd0, 32'd0);
    tick();
    check_head("sll", 32'd1, 32'd3, 4'b0001, 5'd10, 1'b0);
    drive(7'b0110011, 3'b111, 1'b1, 5'd11, 32'h1234_5678, 32'h0F0F_0F0F, 32'd0, 32'd0);
    tick();
    check_head("and", 32'h1234_5678, 32'h0F0F_0F0F, 4'b0111, 5'd11, 1'b0);
    drive(7'b1101111, 3'b000, 1'b0, 5'd1, 32'd55, 32'd66, 32'h0000_0800, 32'h0000_0100);
    tick();
    check_head("jal", 32'h0000_0100, 32'd4, 4'b0000, 5'd1, 1'b0);
    drive(7'b0110111, 3'b000, 1'b1, 5'd12, 32'd99, 32'd0, 32'hABCD_E000, 32'h0000_0200);
    tick();
    check_head("lui", 32'd0, 32'hABCD_E000, 4'b0000, 5'd12, 1'b0);
    drive(7'b0010111, 3'b000, 1'b0, 5'd13, 32'd99, 32'd0, 32'h0000_1000, 32'h0000_0300);
    tick();
    check_head("auipc", 32'h0000_0300, 32'h0000_1000, 4'b0000, 5'd13, 1'b0);
    drive(7'b0100011, 3'b010, 1'b0, 5'd14, 32'h0000_4000, 32'd7, 32'hFFFF_FFFC, 32'd0);
    tick();
    check_head("store", 32'h0000_4000, 32'hFFFF_FFFC, 4'b0000, 5'd14, 1'b0);
    drive(7'b1110011, 3'b000, 1'b1, 5'd15, 32'd5, 32'd6, 32'd7, 32'd8);
    tick();
    check_head("illegal", 32'd0, 32'd0, 4'b0000, 5'd15, 1'b1);
    valid_in = 1'b0;
    tick();
    check("drain_valid", {31'd0, valid_out}, 32'd0);
    check("drain_ready", {31'd0, ready_out}, 32'd1);

    // Backpressure: three back-to-back pushes with the ALU stalled
    ready_in = 1'b0;
    drive(7'b0110011, 3'b000, 1'b0, 5'd1, 32'd100, 32'd1, 32'd0, 32'd0);
    tick();
    check("bp_ready_1", {31'd0, ready_out}, 32'd1);
    check_head("bp_a", 32'd100, 32'd1, 4'b0000, 5'd1, 1'b0);
    drive(7'b0110011, 3'b000, 1'b0, 5'd2, 32'd200, 32'd2, 32'd0, 32'd0);
    tick();
    check("bp_ready_2", {31'd0, ready_out}, 32'd0);
    check_head("bp_a_hold", 32'd100, 32'd1, 4'b0000, 5'd1, 1'b0);
    drive(7'b0110011, 3'b000, 1'b0, 5'd3, 32'd300, 32'd3, 32'd0, 32'd0);
    tick();
    check("bp_ready_3", {31'd0, ready_out}, 32'd0);
    check_head("bp_a_hold2", 32'd100, 32'd1, 4'b0000, 5'd1, 1'b0);
    ready_in = 1'b1;
    tick();
    check_head("bp_b", 32'd200, 32'd2, 4'b0000, 5'd2, 1'b0);
    check("bp_ready_4", {31'd0, ready_out}, 32'd1);
    tick();
    check_head("bp_c", 32'd300, 32'd3, 4'b0000, 5'd3, 1'b0);
    valid_in = 1'b0;
    tick();
    check("bp_done_valid", {31'd0, valid_out}, 32'd0);

    // Flush at count=2 with valid_in asserted
    ready_in = 1'b0;
    drive(7'b0110011, 3'b000, 1'b0, 5'd4, 32'd1, 32'd1, 32'd0, 32'd0);
    tick();
    drive(7'b0110011, 3'b000, 1'b0, 5'd5, 32'd2, 32'd2, 32'd0, 32'd0);
    tick();
    check("fl_full_ready", {31'd0, ready_out}, 32'd0);
    drive(7'b0110011, 3'b000, 1'b0, 5'd6, 32'd3, 32'd3, 32'd0, 32'd0);
    flush_in = 1'b1;
    tick();
    check("fl_valid", {31'd0, valid_out}, 32'd0);
    check("fl_ready", {31'd0, ready_out}, 32'd1);
    // Flush at count=1 with a real push in the same cycle: push must be dropped
    flush_in = 1'b0;
    drive(7'b0110011, 3'b000, 1'b0, 5'd16, 32'd4, 32'd4, 32'd0, 32'd0);
    tick();
    check("fl1_valid_pre", {31'd0, valid_out}, 32'd1);
    drive(7'b0110011, 3'b000, 1'b0, 5'd17, 32'd5, 32'd5, 32'd0, 32'd0);
    flush_in = 1'b1;
    tick();
    flush_in = 1'b0;
    valid_in = 1'b0;
    check("fl1_valid", {31'd0, valid_out}, 32'd0);
    tick();
    check("fl1_dropped", {31'd0, valid_out}, 32'd0);
    check("fl1_ready", {31'd0, ready_out}, 32'd1);

    // Asynchronous reset with the buffer full
    drive(7'b0110011, 3'b000, 1'b1, 5'd20, 32'd9, 32'd9, 32'd0, 32'd0);
    tick();
    drive(7'b0110011, 3'b110, 1'b0, 5'd21, 32'd8, 32'd8, 32'd0, 32'd0);
    tick();
    check("rs_full_ready", {31'd0, ready_out}, 32'd0);
    valid_in = 1'b0;
    #2;
    rst_in = 1'b1;
    #1;
    check_empty_zero("rs_async");
    tick();
    rst_in = 1'b0;
    tick();
    check_empty_zero("rs_after");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
